// File: rtl/inst_fetch_unit.sv
// Fetch stage: samples the PC, runs one req/ready memory transaction, presents the word to decode.
// Two cycles per fetch minimum; a one-entry skid absorbs a completion while decode stalls, and no new request issues until it drains.
module inst_fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IMEM_BYTES = 64
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] inst_address,
   output logic                  pc_advance,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_instruction,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [ADDR_WIDTH-1:0] id_pc_plus4,
   output logic                  id_fault,
   input  logic                  flush
);

   typedef enum logic [1:0] {IDLE, WAIT, SKID, DRAIN} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] inst;
      logic [ADDR_WIDTH-1:0] pc;
      logic                  fault;
   } entry_t;

   localparam logic [ADDR_WIDTH:0]   IMEM_LIM = (ADDR_WIDTH+1)'(IMEM_BYTES);
   localparam logic [ADDR_WIDTH-1:0] FOUR     = ADDR_WIDTH'(4);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] req_addr;
   entry_t                skid, comp;
   logic                  legal, issue, complete, out_free;

   assign legal = (inst_address[1:0] == 2'b00) &&
                  ((IMEM_BYTES == 0) || ({1'b0, inst_address} < IMEM_LIM));
   assign out_free = !id_valid || id_ready;

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      complete   = 1'b0;
      comp.inst  = mem_rdata;
      comp.pc    = req_addr;
      comp.fault = 1'b0;
      case (state)
         IDLE: begin
            if (!flush) begin
               if (legal) begin
                  issue     = 1'b1;
                  state_nxt = WAIT;
               end else begin
                  // Illegal address completes immediately with a zero word.
                  complete   = 1'b1;
                  comp.inst  = '0;
                  comp.pc    = inst_address;
                  comp.fault = 1'b1;
               end
            end
         end
         WAIT: begin
            if (flush)          state_nxt = mem_ready ? IDLE : DRAIN;
            else if (mem_ready) complete  = 1'b1;
         end
         SKID: begin
            if (flush || id_ready) state_nxt = IDLE;
         end
         DRAIN: begin
            if (mem_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (complete) state_nxt = out_free ? IDLE : SKID;
      pc_advance = complete;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         req_addr       <= '0;
         mem_req        <= 1'b0;
         mem_addr       <= '0;
         id_valid       <= 1'b0;
         id_instruction <= '0;
         id_pc          <= '0;
         id_pc_plus4    <= '0;
         id_fault       <= 1'b0;
         skid           <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) req_addr <= inst_address;

         if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= inst_address;
         end else if ((state == WAIT || state == DRAIN) && mem_ready) begin
            mem_req <= 1'b0;
         end

         if (flush) begin
            id_valid <= 1'b0;
         end else if (complete && out_free) begin
            id_valid       <= 1'b1;
            id_instruction <= comp.inst;
            id_pc          <= comp.pc;
            id_pc_plus4    <= comp.pc + FOUR;
            id_fault       <= comp.fault;
         end else if (complete) begin
            skid <= comp;
         end else if (state == SKID && id_ready) begin
            id_valid       <= 1'b1;
            id_instruction <= skid.inst;
            id_pc          <= skid.pc;
            id_pc_plus4    <= skid.pc + FOUR;
            id_fault       <= skid.fault;
         end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: the bench acts as PC and memory, predicts each fetched word
// from the address it presented, and a monitor checks decode-side outputs in order.
module tb_inst_fetch_unit;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        fault;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] inst_address = 32'h0;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        id_ready = 1'b0;
   logic        flush = 1'b0;
   logic        pc_advance, mem_req, id_valid, id_fault;
   logic [31:0] mem_addr, id_instruction, id_pc, id_pc_plus4;

   logic        w_pc_advance, w_mem_req, w_id_valid, w_id_fault;
   logic [31:0] w_mem_addr, w_id_instruction, w_id_pc, w_id_pc_plus4;

   int          tests = 0;
   int          fails = 0;
   exp_t        q[$];
   logic [31:0] mem [16];
   bit          in_reset = 1'b1;
   bit          wrap_done = 1'b0;
   logic        prev_req = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   inst_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IMEM_BYTES(64)) dut (
      .clock(clock), .reset_n(reset_n), .inst_address(inst_address), .pc_advance(pc_advance),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .id_valid(id_valid), .id_ready(id_ready), .id_instruction(id_instruction), .id_pc(id_pc),
      .id_pc_plus4(id_pc_plus4), .id_fault(id_fault), .flush(flush)
   );

   inst_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IMEM_BYTES(0)) u_wrap (
      .clock(clock), .reset_n(reset_n), .inst_address(32'hFFFF_FFFC), .pc_advance(w_pc_advance),
      .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rdata(32'h0000_0013), .mem_ready(1'b1),
      .id_valid(w_id_valid), .id_ready(1'b1), .id_instruction(w_id_instruction), .id_pc(w_id_pc),
      .id_pc_plus4(w_id_pc_plus4), .id_fault(w_id_fault), .flush(1'b0)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < 64);
   endfunction

   // What decode should see for a fetch of address a.
   function automatic exp_t model(input logic [31:0] a);
      exp_t e;
      e.fault = !is_legal(a);
      e.ins   = e.fault ? 32'h0 : mem[a / 4];
      e.pc    = a;
      e.pc4   = a + 32'd4;
      return e;
   endfunction

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 18)) * 4;
      return 32'($urandom_range(0, 80));
   endfunction

   function automatic logic [31:0] next_addr(input logic [31:0] a);
      if ($urandom_range(0, 19) < 14 && a < 32'h40) return a + 32'd4;
      return rand_addr();
   endfunction

   task automatic cycle(input bit stream, output bit adv);
      bit fl;
      @(negedge clock);
      if (mem_req && !prev_req)
         check("mem_req_issue", 128'({is_legal(mem_addr), mem_addr}), 128'({1'b1, inst_address}));
      else if (mem_req)
         check("mem_addr_stable", 128'(mem_addr), 128'(prev_addr));
      prev_req  = mem_req;
      prev_addr = mem_addr;
      flush     = stream ? 1'b0 : ($urandom_range(0, 19) == 0);
      id_ready  = stream ? 1'b1 : ($urandom_range(0, 9) < 6);
      mem_ready = mem_req && (stream || $urandom_range(0, 3) < 2);
      mem_rdata = mem_ready ? mem[mem_addr / 4] : $urandom();
      #1;
      adv = pc_advance;
      fl  = flush;
      if (fl) check("no_advance_on_flush", 128'(pc_advance), 128'(0));
      if (adv) q.push_back(model(inst_address));
      if (fl) q.delete();
      @(posedge clock);
      #1;
      if (adv) inst_address = stream ? ((inst_address + 32'd4) & 32'h3C) : next_addr(inst_address);
      else if (fl) inst_address = rand_addr();
   endtask

   task automatic run(input int n, input bit stream, output int advances);
      int idle = 0;
      bit adv;
      advances = 0;
      for (int i = 0; i < n; i++) begin
         cycle(stream, adv);
         if (adv) begin
            advances++;
            idle = 0;
         end else if (++idle > 60) begin
            fails++;
            tests++;
            $display("FAIL progress_timeout: no pc_advance for %0d cycles", idle);
            idle = 0;
         end
      end
   endtask

   // Monitor: every accepted decode transfer must match the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (!in_reset && reset_n && id_valid && id_ready && !flush) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_output: got pc %h with nothing expected", id_pc);
            end else begin
               e = q.pop_front();
               check("id_output", 128'({id_instruction, id_pc, id_pc_plus4, id_fault}), 128'(e));
            end
         end
      end
   end

   initial begin
      bit seen = 1'b0;
      wait (reset_n === 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (w_id_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("wrap_valid", 128'(seen), 128'(1));
      check("wrap_output", 128'({w_id_instruction, w_id_pc, w_id_pc_plus4, w_id_fault}),
            128'({32'h13, 32'hFFFF_FFFC, 32'h0, 1'b0}));
      wrap_done = 1'b1;
   end

   initial begin
      int  n;
      bit  adv;
      for (int i = 0; i < 16; i++) mem[i] = $urandom();
      #1;
      check("reset_req", 128'({mem_req, mem_addr, pc_advance}), 128'(0));
      check("reset_id", 128'({id_valid, id_instruction, id_pc, id_pc_plus4, id_fault}), 128'(0));
      #20;
      @(negedge clock);
      reset_n  = 1'b1;
      in_reset = 1'b0;
      run(1500, 1'b0, n);

      // Reset asserted in the middle of a memory wait.
      for (int i = 0; i < 40 && !mem_req; i++) cycle(1'b0, adv);
      check("reset_found_wait", 128'(mem_req), 128'(1));
      @(negedge clock);
      in_reset  = 1'b1;
      mem_ready = 1'b0;
      flush     = 1'b0;
      reset_n   = 1'b0;
      #1;
      check("midreset_outputs", 128'({mem_req, id_valid, pc_advance}), 128'(0));
      q.delete();
      prev_req = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      in_reset = 1'b0;

      // Zero-wait streaming: one fetch every two cycles.
      run(6, 1'b1, n);
      run(40, 1'b1, n);
      check("stream_rate", 128'(n), 128'(20));

      run(1500, 1'b0, n);
      run(6, 1'b1, n);
      check("queue_depth_ok", 128'(q.size() <= 2), 128'(1));
      check("wrap_done", 128'(wrap_done), 128'(1));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
